// File: rtl/led_status_arbiter.sv
// Round-robin owner of the six active-low board LEDs; shows a latched requester pattern per slot.
// Optional idle heartbeat is enabled by defining LED_ARB_HEARTBEAT_EN.
module led_status_arbiter #(
  parameter int unsigned WAIT_TIME  = 13500000,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [6*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic [5:0]         led
);

  localparam int unsigned PW = $clog2(WAIT_TIME);
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned IW = $clog2(N_REQ);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(WAIT_TIME - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(WAIT_TIME - 2);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

  typedef enum logic {StIdle, StShow} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [HW-1:0] hold_q;
  logic [IW-1:0] last_q;
  logic [5:0]    pat_q;
  logic [5:0]    idle_led;
  logic          tick;
  logic          found;
  logic [IW-1:0] winner;
  logic [5:0]    pat_sel;
  int unsigned   idx;

`ifdef LED_ARB_HEARTBEAT_EN
  logic [5:0] hb_q;
  assign idle_led = ~hb_q;
`else
  assign idle_led = 6'h3F;
`endif

  assign tick = (presc_q == PRESC_MAX);

  // Search starts just after the previous winner, so it has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last_q) + i) % N_REQ;
      if (!found && req[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    pat_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == IW'(i)) pat_sel = pattern[6*i +: 6];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      hold_q  <= '0;
      last_q  <= IW'(N_REQ - 1);
      pat_q   <= '0;
      grant   <= '0;
      ack     <= '0;
      led     <= 6'h3F;
`ifdef LED_ARB_HEARTBEAT_EN
      hb_q    <= '0;
`endif
    end else begin
      ack <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            // A tick coinciding with the grant is dropped: presc restarts here.
            state_q <= StShow;
            last_q  <= winner;
            pat_q   <= pat_sel;
            grant   <= N_REQ'(1) << winner;
            led     <= ~pat_sel;
            presc_q <= '0;
            hold_q  <= '0;
          end else begin
`ifdef LED_ARB_HEARTBEAT_EN
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
              hb_q <= hb_q + 6'd1;
              led  <= ~(hb_q + 6'd1);
            end
`else
            presc_q <= '0;
            led     <= 6'h3F;
`endif
          end
        end
        StShow: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          led     <= ~pat_q;
          if (tick) hold_q <= hold_q + 1'b1;
          // Registered ack: arm one cycle ahead of the final tick.
          if (hold_q == HOLD_LAST && presc_q == PRESC_PRE) ack <= grant;
          if (tick && hold_q == HOLD_LAST) begin
            state_q <= StIdle;
            grant   <= '0;
            presc_q <= '0;
            led     <= idle_led;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_arbiter.sv
// Randomized scoreboard bench for led_status_arbiter against a slot-level reference model.
// Honours LED_ARB_HEARTBEAT_EN the same way as the design.
module tb_led_status_arbiter;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [6*N-1:0] pattern = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [5:0]     led;

  led_status_arbiter #(
    .WAIT_TIME (W),
    .N_REQ     (N),
    .HOLD_TICKS(H)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .pattern(pattern),
    .grant  (grant),
    .ack    (ack),
    .led    (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] a;
    logic [5:0]   l;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: a slot is "left" cycles of display; idle phase counts prescaler cycles.
  bit         m_show = 1'b0;
  int         m_win  = 0;
  int         m_left = 0;
  int         m_last = N - 1;
  int         m_ph   = 0;
  logic [5:0] m_pat  = '0;
  logic [5:0] m_hb   = '0;

  task automatic model_step();
    exp_t x;
    bit   hit;
    int   w;
    if (rst) begin
      m_show = 1'b0;
      m_ph   = 0;
      m_hb   = '0;
      m_last = N - 1;
    end else if (!m_show) begin
      hit = 1'b0;
      w   = 0;
      for (int k = 1; k <= N; k++) begin
        if (!hit && req[(m_last + k) % N]) begin
          hit = 1'b1;
          w   = (m_last + k) % N;
        end
      end
      if (hit) begin
        m_show = 1'b1;
        m_win  = w;
        m_last = w;
        m_left = H * W;
        m_pat  = pattern[6*w +: 6];
        m_ph   = 0;
      end else begin
`ifdef LED_ARB_HEARTBEAT_EN
        if (m_ph == W - 1) begin
          m_ph = 0;
          m_hb = m_hb + 6'd1;
        end else begin
          m_ph = m_ph + 1;
        end
`endif
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_show = 1'b0;
        m_ph   = 0;
      end
    end
    x.g = m_show ? N'(1) << m_win : '0;
    x.a = (m_show && m_left == 1) ? N'(1) << m_win : '0;
`ifdef LED_ARB_HEARTBEAT_EN
    x.l = m_show ? ~m_pat : ~m_hb;
`else
    x.l = m_show ? ~m_pat : 6'h3F;
`endif
    expq.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [6*N-1:0] p);
    @(negedge clk);
    rst     = r;
    req     = rq;
    pattern = p;
    model_step();
  endtask

  function automatic logic [6*N-1:0] rpat();
    return (6*N)'($urandom());
  endfunction

  // Monitor: every cycle the DUT presents grant/ack/led, compare against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        total++;
        if ({grant, ack, led} !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got grant=%b ack=%b led=%h expected grant=%b ack=%b led=%h",
                   $time, grant, ack, led, e.g, e.a, e.l);
        end
      end
    end
  end

  initial begin
    logic [6*N-1:0] p;
    logic [N-1:0]   rq;
    logic           r;
    repeat (2) cyc(1'b1, '0, '0);
    repeat (40) cyc(1'b0, '0, rpat());
    // Single request, pattern 2A on requester 0.
    p = rpat();
    p[5:0] = 6'h2A;
    cyc(1'b0, 4'b0001, p);
    repeat (12) cyc(1'b0, '0, p);
    // All requesting continuously.
    repeat (50) cyc(1'b0, 4'hF, rpat());
    // Requester 2 alone, drops req and changes pattern mid-slot.
    repeat (10) cyc(1'b0, '0, rpat());
    cyc(1'b0, 4'b0100, rpat());
    repeat (12) cyc(1'b0, '0, rpat());
    // Reset three cycles into a slot, then all requesting.
    cyc(1'b0, 4'b0010, rpat());
    repeat (3) cyc(1'b0, '0, rpat());
    cyc(1'b1, '0, rpat());
    repeat (30) cyc(1'b0, 4'hF, rpat());
    // Random traffic with occasional resets.
    rq = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) rq = N'($urandom());
      r = ($urandom_range(99) == 0);
      cyc(r, rq, rpat());
    end
    repeat (5) cyc(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
